// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and responder FSM state types.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi_lite_strb_merge.sv
// Byte-strobe merge: each byte of the result comes from wdata when its strobe is set,
// otherwise from the old word.
module axi_lite_strb_merge #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   merged
);

  // Per-byte select between old and new data
  always_comb begin
    merged = old_word;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      if (wstrb[b]) begin
        merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite responder backed by NUM_REGS read/write registers with byte strobes.
// Independent write (AW/W in any order) and read channels, one outstanding each.
// All outputs are registered; register contents are exported on o_reg_flat.
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'h0100_0000)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          i_axi_awaddr,
  input  logic                           i_axi_awvalid,
  output logic                           o_axi_awready,
  input  logic [DATA_WIDTH-1:0]          i_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_axi_wstrb,
  input  logic                           i_axi_wvalid,
  output logic                           o_axi_wready,
  output logic [1:0]                     o_axi_bresp,
  output logic                           o_axi_bvalid,
  input  logic                           i_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          i_axi_araddr,
  input  logic                           i_axi_arvalid,
  output logic                           o_axi_arready,
  output logic [DATA_WIDTH-1:0]          o_axi_rdata,
  output logic [1:0]                     o_axi_rresp,
  output logic                           o_axi_rvalid,
  input  logic                           i_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_flat
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_t              w_state_q;
  logic                  awready_q, wready_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  aw_hs, w_hs, have_aw, have_w, commit;
  logic [ADDR_WIDTH-1:0] cur_awaddr, w_offset, w_word;
  logic [DATA_WIDTH-1:0] cur_wdata, merged_word;
  logic [STRB_W-1:0]     cur_wstrb;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;

  // Handshake detection and selection between held and live AW/W beats
  always_comb begin
    aw_hs      = i_axi_awvalid && awready_q;
    w_hs       = i_axi_wvalid && wready_q;
    have_aw    = aw_held_q || aw_hs;
    have_w     = w_held_q || w_hs;
    commit     = (w_state_q == W_IDLE) && have_aw && have_w;
    cur_awaddr = aw_held_q ? awaddr_q : i_axi_awaddr;
    cur_wdata  = w_held_q ? wdata_q : i_axi_wdata;
    cur_wstrb  = w_held_q ? wstrb_q : i_axi_wstrb;
    // Comparing the word offset is equivalent to offset < NUM_REGS*4; an address
    // below BASE_ADDR wraps to a huge offset and misses.
    w_offset   = cur_awaddr - BASE_ADDR;
    w_word     = w_offset >> 2;
    w_hit      = w_word < ADDR_WIDTH'(NUM_REGS);
    w_idx      = w_word[IDX_W-1:0];
  end

  axi_lite_strb_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_strb_merge (
    .old_word(regs_q[w_idx]),
    .wdata   (cur_wdata),
    .wstrb   (cur_wstrb),
    .merged  (merged_word)
  );

  // Write FSM: capture AW/W independently, commit on the second, then hold B
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (commit) begin
            w_state_q <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= w_hit ? RESP_OKAY : RESP_DECERR;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              awaddr_q  <= i_axi_awaddr;
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              wdata_q  <= i_axi_wdata;
              wstrb_q  <= i_axi_wstrb;
            end
            // Also raises the readys on the first cycle after reset
            awready_q <= !have_aw;
            wready_q  <= !have_w;
          end
        end
        W_RESP: begin
          if (i_axi_bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Register array: updated on the commit edge of a decoded write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (commit && w_hit) begin
      regs_q[w_idx] <= merged_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_t              r_state_q;
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  ar_hs, r_hit;
  logic [ADDR_WIDTH-1:0] r_offset, r_word;
  logic [IDX_W-1:0]      r_idx;

  // Read address decode
  always_comb begin
    ar_hs    = i_axi_arvalid && arready_q;
    r_offset = i_axi_araddr - BASE_ADDR;
    r_word   = r_offset >> 2;
    r_hit    = r_word < ADDR_WIDTH'(NUM_REGS);
    r_idx    = r_word[IDX_W-1:0];
  end

  // Read FSM: sample the array on AR handshake (pre-write value on a same-edge commit)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= r_hit ? regs_q[r_idx] : '0;
            rresp_q   <= r_hit ? RESP_OKAY : RESP_DECERR;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (i_axi_rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Output wiring
  always_comb begin
    o_reg_flat = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      o_reg_flat[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end
  end

  assign o_axi_awready = awready_q;
  assign o_axi_wready  = wready_q;
  assign o_axi_bvalid  = bvalid_q;
  assign o_axi_bresp   = bresp_q;
  assign o_axi_arready = arready_q;
  assign o_axi_rvalid  = rvalid_q;
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Scoreboard bench for axi_lite_slave_regfile: stimulus pushes expected B/R responses,
// a monitor pops and compares them on each B/R handshake.
module tb_axi_lite_slave_regfile;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  awaddr, wdata, araddr;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_arready, o_axi_rvalid;
  logic [1:0]   o_axi_bresp, o_axi_rresp;
  logic [31:0]  o_axi_rdata;
  logic [511:0] o_reg_flat;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic [1:0]  exp_b[$];
  r_exp_t      exp_r[$];
  logic [31:0] model [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  axi_lite_slave_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .i_axi_awaddr (awaddr),
    .i_axi_awvalid(awvalid),
    .o_axi_awready(o_axi_awready),
    .i_axi_wdata  (wdata),
    .i_axi_wstrb  (wstrb),
    .i_axi_wvalid (wvalid),
    .o_axi_wready (o_axi_wready),
    .o_axi_bresp  (o_axi_bresp),
    .o_axi_bvalid (o_axi_bvalid),
    .i_axi_bready (bready),
    .i_axi_araddr (araddr),
    .i_axi_arvalid(arvalid),
    .o_axi_arready(o_axi_arready),
    .o_axi_rdata  (o_axi_rdata),
    .o_axi_rresp  (o_axi_rresp),
    .o_axi_rvalid (o_axi_rvalid),
    .i_axi_rready (rready),
    .o_reg_flat   (o_reg_flat)
  );

  function automatic void check(input string name, input logic [511:0] act,
                                input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int k = 0; k < 16; k++) f[k*32 +: 32] = model[k];
    return f;
  endfunction

  // Monitor: compare each B/R handshake against the head of its queue
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && o_axi_bvalid && bready) begin
        if (exp_b.size() == 0) check("unexpected_b", 1, 0);
        else check("bresp", o_axi_bresp, exp_b.pop_front());
      end
      if (!reset && o_axi_rvalid && rready) begin
        if (exp_r.size() == 0) check("unexpected_r", 1, 0);
        else begin
          r_exp_t e;
          e = exp_r.pop_front();
          check("rdata", o_axi_rdata, e.data);
          check("rresp", o_axi_rresp, e.resp);
        end
      end
    end
  end

  // All tasks start and end #1 after a rising edge
  task automatic wait_aw_w_ready();
    int n = 0;
    while (!(o_axi_awready && o_axi_wready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check("aw_w_ready_timeout", n, 0);
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] resp);
    exp_b.push_back(resp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    wait_aw_w_ready();
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] resp);
    int n = 0;
    exp_r.push_back('{data: d, resp: resp});
    araddr = a; arvalid = 1'b1;
    while (!o_axi_arready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check("ar_ready_timeout", n, 0);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] resp);
    issue_write(a, d, s, resp);
    @(negedge clk);
    check("b_latency", o_axi_bvalid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    issue_read(a, d, resp);
    @(negedge clk);
    check("r_latency", o_axi_rvalid, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) model[k] = 32'h0;
    reset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;

    // Reset state and ready timing
    @(posedge clk);
    @(negedge clk);
    check("rst_awready", o_axi_awready, 1'b0);
    check("rst_arready", o_axi_arready, 1'b0);
    check("rst_bvalid", o_axi_bvalid, 1'b0);
    check("rst_rvalid", o_axi_rvalid, 1'b0);
    check("rst_rdata", o_axi_rdata, 32'h0);
    check("rst_flat", o_reg_flat, 512'h0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("ready_delay_wready", o_axi_wready, 1'b0);
    @(negedge clk);
    check("ready_up_aw", o_axi_awready, 1'b1);
    check("ready_up_w", o_axi_wready, 1'b1);
    check("ready_up_ar", o_axi_arready, 1'b1);
    @(posedge clk); #1;

    // 1: AW+W same cycle, then read back
    do_write(32'h0100_0004, 32'hDEAD_BEEF, 4'hF, OKAY);
    model[1] = 32'hDEAD_BEEF;
    check("flat_t1", o_reg_flat, model_flat());
    do_read(32'h0100_0004, 32'hDEAD_BEEF, OKAY);

    // 2: W first, AW three cycles later, partial strobes
    exp_b.push_back(OKAY);
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("w_held_wready", o_axi_wready, 1'b0);
    check("w_held_awready", o_axi_awready, 1'b1);
    check("w_held_bvalid", o_axi_bvalid, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    awaddr = 32'h0100_0000; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("b_latency_t2", o_axi_bvalid, 1'b1);
    @(posedge clk); #1;
    model[0] = 32'h0022_0044;
    check("flat_t2", o_reg_flat, model_flat());
    do_read(32'h0100_0000, 32'h0022_0044, OKAY);

    // 3: decode boundaries
    do_read(32'h0200_0000, 32'h0, DECERR);
    do_write(32'h0200_0000, 32'hFFFF_FFFF, 4'hF, DECERR);
    check("flat_t3_miss", o_reg_flat, model_flat());
    do_read(32'h0100_0040, 32'h0, DECERR);
    do_read(32'h00FF_FFFC, 32'h0, DECERR);
    do_write(32'h0100_003F, 32'hCAFE_F00D, 4'hF, OKAY);
    model[15] = 32'hCAFE_F00D;
    check("flat_t3_top", o_reg_flat, model_flat());
    do_read(32'h0100_003C, 32'hCAFE_F00D, OKAY);

    // 4: backpressure on B and R
    bready = 1'b0;
    issue_write(32'h0100_000C, 32'h1234_5678, 4'hF, OKAY);
    model[3] = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid", o_axi_bvalid, 1'b1);
      check("bp_bresp", o_axi_bresp, OKAY);
      check("bp_awready", o_axi_awready, 1'b0);
      check("bp_wready", o_axi_wready, 1'b0);
    end
    @(posedge clk); #1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    issue_read(32'h0100_000C, 32'h1234_5678, OKAY);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rvalid", o_axi_rvalid, 1'b1);
      check("bp_rdata", o_axi_rdata, 32'h1234_5678);
      check("bp_arready", o_axi_arready, 1'b0);
    end
    @(posedge clk); #1; rready = 1'b1;
    @(posedge clk); #1;
    check("flat_t4", o_reg_flat, model_flat());

    // 5: read on the commit edge of a write to the same register
    do_write(32'h0100_0008, 32'h0000_000A, 4'hF, OKAY);
    exp_b.push_back(OKAY);
    exp_r.push_back('{data: 32'h0000_000A, resp: OKAY});
    awaddr = 32'h0100_0008; wdata = 32'h0000_000B; wstrb = 4'hF;
    araddr = 32'h0100_0008;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("t5_bvalid", o_axi_bvalid, 1'b1);
    check("t5_rvalid", o_axi_rvalid, 1'b1);
    @(posedge clk); #1;
    model[2] = 32'h0000_000B;
    do_read(32'h0100_0008, 32'h0000_000B, OKAY);
    check("flat_t5", o_reg_flat, model_flat());

    // 6: reset while in W_RESP aborts the response
    bready = 1'b0;
    awaddr = 32'h0100_0010; wdata = 32'h0000_0055; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t6_bvalid_pre", o_axi_bvalid, 1'b1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    for (int k = 0; k < 16; k++) model[k] = 32'h0;
    @(negedge clk);
    check("t6_bvalid", o_axi_bvalid, 1'b0);
    check("t6_flat", o_reg_flat, model_flat());
    check("t6_awready_low", o_axi_awready, 1'b0);
    @(posedge clk); #1;
    check("t6_awready", o_axi_awready, 1'b1);
    check("t6_wready", o_axi_wready, 1'b1);
    check("t6_arready", o_axi_arready, 1'b1);
    bready = 1'b1;
    @(negedge clk);
    check("t6_no_stale_b", o_axi_bvalid, 1'b0);
    @(posedge clk); #1;
    do_read(32'h0100_0004, 32'h0, OKAY);

    repeat (3) @(posedge clk);
    check("drain_b", exp_b.size(), 0);
    check("drain_r", exp_r.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
